// File: rtl/board_mem_arbiter_if.sv
// Requester-side and RAM-side signals of the board memory arbiter, grouped for port binding.
// Handshake: req_i[k] is a level ownership request; each cycle with req_i[k] & gnt_o[k] is one access,
// and rvalid_o[k] qualifies the broadcast rdata_o for a read requester k issued.
interface board_mem_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 2
);
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*ADDR_W-1:0] addr_i;
  logic [N_REQ*DATA_W-1:0] wdata_i;
  logic [N_REQ-1:0]        wren_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        rvalid_o;
  logic [DATA_W-1:0]       rdata_o;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_data;
  logic                    ram_wren;
  logic [DATA_W-1:0]       ram_q;
  logic                    busy_o;
  logic                    timeout_o;

  modport slave (
    input  req_i, addr_i, wdata_i, wren_i, ram_q,
    output gnt_o, rvalid_o, rdata_o, ram_addr, ram_data, ram_wren, busy_o, timeout_o
  );

  // System side: requesters plus the RAM returning ram_q.
  modport master (
    output req_i, addr_i, wdata_i, wren_i, ram_q,
    input  gnt_o, rvalid_o, rdata_o, ram_addr, ram_data, ram_wren, busy_o, timeout_o
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// Request/grant arbiter with burst ownership, tagged read returns and a drain phase for gameboardRAM.
// Optional feature macro: BMA_TIMEOUT_EN (bounded hold time with forced revoke).
module board_mem_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 2,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clock,
  input  logic                reset,
  board_mem_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DRN_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state, state_n;
  logic [OWN_W-1:0]   owner, owner_n;
  logic [N_REQ-1:0]   gnt, gnt_n;
  logic [DRN_W-1:0]   drain_cnt, drain_n;
  logic [N_REQ-1:0]   req_eff;
  logic               hold_expired;
  logic               issue;
  logic [RD_LAT-1:0]  rd_v;
  logic [OWN_W-1:0]   rd_tag [RD_LAT];

  function automatic logic [OWN_W-1:0] pick(input logic [N_REQ-1:0] r);
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (r[k]) pick = OWN_W'(k);
    end
  endfunction

  function automatic logic [N_REQ-1:0] decode(input logic [OWN_W-1:0] o);
    decode = '0;
    decode[o] = 1'b1;
  endfunction

`ifdef BMA_TIMEOUT_EN
  localparam int HOLD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_REQ-1:0]  mask;
  logic              revoke;
  logic              timeout_q;

  assign hold_expired = (hold_cnt == HOLD_W'(TIMEOUT_CYC - 1));
  assign revoke       = (state == GRANT) && bus.req_i[owner] && hold_expired;

  // A revoked requester stays out of arbitration until it drops its request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt  <= '0;
      mask      <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
      mask      <= (mask | (revoke ? decode(owner) : '0)) & bus.req_i;
      timeout_q <= revoke;
    end
  end

  assign req_eff       = bus.req_i & ~mask;
  assign bus.timeout_o = timeout_q;
`else
  assign hold_expired  = 1'b0;
  assign req_eff       = bus.req_i;
  assign bus.timeout_o = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      gnt       <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      gnt       <= gnt_n;
      drain_cnt <= drain_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    gnt_n   = gnt;
    drain_n = drain_cnt;
    case (state)
      IDLE: begin
        if (|req_eff) begin
          owner_n = pick(req_eff);
          gnt_n   = decode(pick(req_eff));
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req_i[owner] || hold_expired) begin
          gnt_n   = '0;
          drain_n = '0;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        // Arbitration happens only on the final drain cycle so owners never interleave.
        if (drain_cnt == DRN_W'(RD_LAT - 1)) begin
          if (|req_eff) begin
            owner_n = pick(req_eff);
            gnt_n   = decode(pick(req_eff));
            state_n = GRANT;
          end else begin
            state_n = IDLE;
          end
        end else begin
          drain_n = drain_cnt + 1'b1;
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign issue        = (state == GRANT) && bus.req_i[owner] && gnt[owner];
  assign bus.ram_addr = issue ? bus.addr_i[owner*ADDR_W +: ADDR_W] : '0;
  assign bus.ram_data = issue ? bus.wdata_i[owner*DATA_W +: DATA_W] : '0;
  assign bus.ram_wren = issue && bus.wren_i[owner];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_v <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_tag[i] <= '0;
    end else begin
      rd_v[0]   <= issue && !bus.wren_i[owner];
      rd_tag[0] <= owner;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_v[i]   <= rd_v[i-1];
        rd_tag[i] <= rd_tag[i-1];
      end
    end
  end

  assign bus.rvalid_o = rd_v[RD_LAT-1] ? decode(rd_tag[RD_LAT-1]) : '0;
  assign bus.rdata_o  = rd_v[RD_LAT-1] ? bus.ram_q : '0;
  assign bus.gnt_o    = gnt;
  assign bus.busy_o   = (state != IDLE);
  assign dbg_state    = state;
endmodule
